// File: rtl/reflect_serializer.sv
// Byte serializer with in-stream full-width bit reflection of an N-byte value.
// Optional macro REFLECT_SERIALIZER_XOROUT_EN adds a per-byte XOR-out stage after reflection.
module reflect_serializer #(
  parameter int MAX_BYTES = 8,
  parameter int BW_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*MAX_BYTES-1:0] in_value,
  input  logic [BW_W-1:0]        in_bytewidth,
  input  logic                   in_reflect,
`ifdef REFLECT_SERIALIZER_XOROUT_EN
  input  logic [8*MAX_BYTES-1:0] in_xorout,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic                   out_last
);

  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                 state_q, state_d;
  logic [8*MAX_BYTES-1:0] value_q, value_d;
  logic                   reflect_q, reflect_d;
  logic [IDX_W-1:0]       lastIdx_q, lastIdx_d;
  logic [IDX_W-1:0]       k_q, k_d;
`ifdef REFLECT_SERIALIZER_XOROUT_EN
  logic [8*MAX_BYTES-1:0] xorout_q, xorout_d;
`endif

  logic [IDX_W-1:0] selIdx;
  logic [7:0]       selByte;
  logic [7:0]       revByte;
  logic [7:0]       xorByte;
  logic [7:0]       sendByte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      value_q   <= '0;
      reflect_q <= 1'b0;
      lastIdx_q <= '0;
      k_q       <= '0;
`ifdef REFLECT_SERIALIZER_XOROUT_EN
      xorout_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      reflect_q <= reflect_d;
      lastIdx_q <= lastIdx_d;
      k_q       <= k_d;
`ifdef REFLECT_SERIALIZER_XOROUT_EN
      xorout_q  <= xorout_d;
`endif
    end
  end

  // Reflected stream walks the captured window from its top byte down, each byte bit-reversed.
  always_comb begin
    selIdx  = reflect_q ? (lastIdx_q - k_q) : k_q;
    selByte = '0;
    xorByte = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (IDX_W'(b) == selIdx) selByte = value_q[8*b +: 8];
`ifdef REFLECT_SERIALIZER_XOROUT_EN
      if (IDX_W'(b) == k_q) xorByte = xorout_q[8*b +: 8];
`endif
    end
    for (int i = 0; i < 8; i++) revByte[i] = selByte[7-i];
    sendByte = (reflect_q ? revByte : selByte) ^ xorByte;
  end

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    reflect_d = reflect_q;
    lastIdx_d = lastIdx_q;
    k_d       = k_q;
`ifdef REFLECT_SERIALIZER_XOROUT_EN
    xorout_d  = xorout_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d   = SEND;
          value_d   = in_value;
          reflect_d = in_reflect;
          k_d       = '0;
`ifdef REFLECT_SERIALIZER_XOROUT_EN
          xorout_d  = in_xorout;
`endif
          // Oversized byte counts clamp to the full width.
          if (32'(in_bytewidth) >= 32'(MAX_BYTES - 1)) lastIdx_d = LAST_IDX;
          else                                         lastIdx_d = IDX_W'(in_bytewidth);
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_byte  = sendByte;
        out_last  = (k_q == lastIdx_q);
        if (out_ready) begin
          if (out_last) state_d = IDLE;
          else          k_d     = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reflect_serializer.sv
// Self-checking bench for reflect_serializer: directed steps plus a byte scoreboard.
// Build with REFLECT_SERIALIZER_XOROUT_EN to also exercise the XOR-out stage.
module tb_reflect_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_value;
  logic [2:0]  in_bytewidth;
  logic        in_reflect;
`ifdef REFLECT_SERIALIZER_XOROUT_EN
  logic [63:0] in_xorout;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  // Each entry is {last, byte}.
  logic [8:0] sb[$];

  logic       prevStall = 1'b0;
  logic [7:0] prevByte  = 8'h00;
  logic       prevLast  = 1'b0;

  reflect_serializer #(.MAX_BYTES(8), .BW_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_value    (in_value),
    .in_bytewidth(in_bytewidth),
    .in_reflect  (in_reflect),
`ifdef REFLECT_SERIALIZER_XOROUT_EN
    .in_xorout   (in_xorout),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_byte    (out_byte),
    .out_last    (out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: reflect the whole N*8-bit window as one word, then slice it LSB byte first.
  task automatic pushExpected(input logic [63:0] value, input int bw, input bit refl, input logic [63:0] xo);
    int n;
    logic [63:0] r;
    logic [7:0]  b;
    n = (bw + 1 > 8) ? 8 : bw + 1;
    r = '0;
    for (int i = 0; i < n*8; i++) begin
      if (refl) r[n*8-1-i] = value[i];
      else      r[i]       = value[i];
    end
    for (int k = 0; k < n; k++) begin
      b = r[8*k +: 8];
`ifdef REFLECT_SERIALIZER_XOROUT_EN
      b = b ^ xo[8*k +: 8];
`endif
      sb.push_back({(k == n-1), b});
    end
  endtask

  task automatic applyStimulus(input logic [63:0] value, input int bw, input bit refl, input logic [63:0] xo);
    int waitCnt = 0;
    while (!in_ready && waitCnt < 200) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("[TB] FAIL accept_timeout: observed in_ready=0, expected 1 within 200 cycles");
    end
    in_valid     = 1'b1;
    in_value     = value;
    in_bytewidth = 3'(bw);
    in_reflect   = refl;
`ifdef REFLECT_SERIALIZER_XOROUT_EN
    in_xorout    = xo;
`endif
    pushExpected(value, bw, refl, xo);
    @(posedge clk); #1;
    in_valid     = 1'b0;
    in_value     = {$urandom, $urandom};
    in_bytewidth = 3'($urandom_range(0, 7));
    in_reflect   = 1'($urandom_range(0, 1));
  endtask

  task automatic waitIdle(input bit randReady);
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk); #1;
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sb.size() == 0 && in_ready && !out_valid) done = 1'b1;
    end
    out_ready = 1'b1;
    if (!done) begin
      checks++;
      errors++;
      $error("[TB] FAIL idle_timeout: observed %0d pending bytes, expected 0", sb.size());
    end
  endtask

  // Scoreboard monitor, plus stability of a stalled byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall <= 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid", 64'(out_valid), 64'd1);
        checkOutput("stall_byte", 64'(out_byte), 64'(prevByte));
        checkOutput("stall_last", 64'(out_last), 64'(prevLast));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("[TB] FAIL extra_byte: observed byte 0x%0h, expected no output", out_byte);
        end else begin
          logic [8:0] exp;
          exp = sb.pop_front();
          checkOutput("sb_byte", 64'(out_byte), 64'(exp[7:0]));
          checkOutput("sb_last", 64'(out_last), 64'(exp[8]));
        end
      end
      prevStall <= out_valid && !out_ready;
      prevByte  <= out_byte;
      prevLast  <= out_last;
    end
  end

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_value     = '0;
    in_bytewidth = '0;
    in_reflect   = 1'b0;
`ifdef REFLECT_SERIALIZER_XOROUT_EN
    in_xorout    = '0;
`endif
    out_ready    = 1'b1;

    #2;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_byte", 64'(out_byte), 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] single byte reflect");
    applyStimulus(64'h01, 0, 1'b1, 64'h0);
    @(negedge clk);
    checkOutput("t1_out_valid", 64'(out_valid), 64'd1);
    checkOutput("t1_in_ready_busy", 64'(in_ready), 64'd0);
    @(negedge clk);
    checkOutput("t1_in_ready_back", 64'(in_ready), 64'd1);
    checkOutput("t1_idle_valid", 64'(out_valid), 64'd0);
    checkOutput("t1_idle_byte", 64'(out_byte), 64'd0);
    checkOutput("t1_idle_last", 64'(out_last), 64'd0);
    waitIdle(1'b0);

    $display("[TB] four byte reflect");
    applyStimulus(64'h12345678, 3, 1'b1, 64'h0);
    waitIdle(1'b0);

    $display("[TB] two byte pass-through, upper bytes ignored");
    applyStimulus(64'hFFFF_FFFF_FFFF_ABCD, 1, 1'b0, 64'h0);
    waitIdle(1'b0);

    $display("[TB] backpressure on second byte");
    applyStimulus(64'h12345678, 3, 1'b1, 64'h0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checkOutput("t4_hold_byte", 64'(out_byte), 64'h2C);
      checkOutput("t4_hold_last", 64'(out_last), 64'd0);
      checkOutput("t4_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    waitIdle(1'b0);

    $display("[TB] reset during third byte");
    applyStimulus(64'h12345678, 3, 1'b1, 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("t5_third_byte", 64'(out_byte), 64'h6A);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_async_byte", 64'(out_byte), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("t5_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    checkOutput("t5_no_resume", 64'(out_valid), 64'd0);
    applyStimulus(64'h0000_00A5_5A0F, 2, 1'b0, 64'h0);
    waitIdle(1'b0);

    $display("[TB] full-width values");
    applyStimulus(64'h0102030405060708, 7, 1'b1, 64'h0);
    waitIdle(1'b0);
    applyStimulus(64'h0102030405060708, 7, 1'b0, 64'h0);
    waitIdle(1'b0);

`ifdef REFLECT_SERIALIZER_XOROUT_EN
    $display("[TB] xorout");
    applyStimulus(64'h12345678, 3, 1'b1, 64'hFFFF_FFFF);
    waitIdle(1'b0);
`endif

    $display("[TB] random values with random backpressure");
    for (int r = 0; r < 10; r++) begin
      applyStimulus({$urandom, $urandom}, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom});
      waitIdle(1'b1);
    end

    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reflect_serializer.md
Name: reflect_serializer

Overview:
Sequential successor to the combinational byte-reflect logic, parametrised in width (MAX_BYTES).
- Accepts a value of up to MAX_BYTES bytes, plus a byte count and a reflect-mode flag, over a valid/ready handshake.
- Emits the result one byte per cycle on an 8-bit output stream with valid/ready/last.
- Sits between the CRC engine's final register and the 8-bit output pins of the CRC design.
- Performs full-width bit reflection in-stream, so no 8*MAX_BYTES-wide reflect network is needed.

Parameters:
- MAX_BYTES, 8, maximum value width in bytes (1..8).
- BW_W, 3, width of in_bytewidth; must be at least clog2(MAX_BYTES), minimum 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream value valid.
- in_ready  output  1  block can accept a value (high only in IDLE).
- in_value  input  8*MAX_BYTES  value; byte k is in_value[8k+7:8k].
- in_bytewidth  input  BW_W  number of bytes minus 1.
- in_reflect  input  1  1 = reflect the whole N-byte window; 0 = pass through.
- out_valid  output  1  out_byte valid.
- out_ready  input  1  downstream accepts the byte.
- out_byte  output  8  current output byte.
- out_last  output  1  high with the final byte of the value.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - in_ready=1 after release; out_valid=0, out_byte=0, out_last=0.
  - All capture registers and the byte counter clear to 0.
  - Reset mid-stream aborts the transfer; no further bytes of that value are emitted.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: in_ready=0, out_valid=1.
- IDLE -> SEND on a rising edge with in_valid=1:
  - Capture in_value, in_reflect and N = min(in_bytewidth+1, MAX_BYTES).
  - Set byte counter k=0.
- Latency: the first byte is valid in the cycle after acceptance.
- SEND output function for byte k:
  - reflect=1: out_byte = bit-reverse of captured byte (N-1-k). The stream then equals the full N*8-bit reflection of the window, least-significant byte first.
  - reflect=0: out_byte = captured byte k.
- out_last = (k == N-1).
- Bytes at or above index N of in_value are ignored.
- Transfer occurs on a cycle with out_valid=1 and out_ready=1:
  - If out_last=1: go to IDLE next cycle. One bubble cycle follows; back-to-back values are not accepted in the same cycle.
  - Else: k increments.
- While out_valid=1 and out_ready=0: out_byte and out_last hold stable; state and k are unchanged.
- out_valid never drops without a transfer, except on reset.
- in_value, in_bytewidth and in_reflect changes during SEND have no effect.
- N is clamped to MAX_BYTES whenever in_bytewidth+1 exceeds MAX_BYTES.
- Outputs in IDLE: out_byte=0, out_last=0.
- Throughput: N bytes in N cycles under continuous out_ready, plus 1 cycle of acceptance overhead.

Optional Feature:
Macro REFLECT_SERIALIZER_XOROUT_EN.
- Defined:
  - Adds input in_xorout [8*MAX_BYTES-1:0], captured together with in_value on acceptance.
  - Emitted byte k is XORed with captured in_xorout byte k, after reflection.
  - Captured in_xorout clears to 0 on reset.
- Undefined: the port is absent and no XOR stage exists; behaviour is exactly as above.

Test Plan:
1. bytewidth=0, value=0x01, reflect=1, out_ready=1 -> single byte 0x80 with out_last=1; in_ready back to 1 two cycles after accept.
2. bytewidth=3, value=0x12345678, reflect=1 -> bytes 0x48, 0x2C, 0x6A, 0x1E on consecutive cycles; out_last only on 0x1E.
3. bytewidth=1, value=0xFFFFFFFFFFFFABCD, reflect=0 -> bytes 0xCD, 0xAB only (upper bytes ignored); out_last on 0xAB.
4. Case 2 with out_ready held low for 3 cycles after the second byte -> out_byte holds 0x2C and out_last holds 0 for those cycles; in_ready stays 0; remaining bytes follow unchanged.
5. rst_n pulsed low during the third byte of case 2 -> out_valid=0 immediately (asynchronous); in_ready=1 after release; a new value is then emitted from k=0.
6. With REFLECT_SERIALIZER_XOROUT_EN defined: case 2 with in_xorout=0xFFFFFFFF -> bytes 0xB7, 0xD3, 0x95, 0xE1.
